// File: rtl/axil_mem_pkg.sv
// Shared definitions for the AXI4-Lite to memory-bus bridge:
// FSM state encodings, AXI response codes and the arbitration helper.
package axil_mem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_MEM_WR = 3'd1,
    ST_MEM_RD = 3'd2,
    ST_B_RESP = 3'd3,
    ST_R_RESP = 3'd4
  } bridge_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Decide which side the next IDLE cycle offers ready to (1 = write, 0 = read).
  // Contention goes to the round-robin owner; a lone requester always wins;
  // with no requester the offer follows the round-robin owner.
  function automatic logic offer_write(input logic want_w, input logic want_r,
                                       input logic pri_write);
    if (want_w && want_r) return pri_write;
    if (want_w) return 1'b1;
    if (want_r) return 1'b0;
    return pri_write;
  endfunction

endpackage

// File: rtl/axil_mem_bridge.sv
// AXI4-Lite slave to single request/response memory bus bridge.
// One transaction in flight; AW and W captured independently, reads and
// writes arbitrated round-robin, every output registered.
// Valid/ready: a transfer happens on a rising clk edge where valid and ready
// are both 1; valid, once raised, holds with stable payload until that edge.
// Optional memory-response watchdog: define MEM_BRIDGE_TIMEOUT_EN.
module axil_mem_bridge
  import axil_mem_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    s_awvalid,
  output logic                    s_awready,
  input  logic [ADDR_WIDTH-1:0]   s_awaddr,
  input  logic [2:0]              s_awprot,
  input  logic                    s_wvalid,
  output logic                    s_wready,
  input  logic [DATA_WIDTH-1:0]   s_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_wstrb,
  output logic                    s_bvalid,
  input  logic                    s_bready,
  output logic [1:0]              s_bresp,
  input  logic                    s_arvalid,
  output logic                    s_arready,
  input  logic [ADDR_WIDTH-1:0]   s_araddr,
  input  logic [2:0]              s_arprot,
  output logic                    s_rvalid,
  input  logic                    s_rready,
  output logic [DATA_WIDTH-1:0]   s_rdata,
  output logic [1:0]              s_rresp,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [ADDR_WIDTH-1:0]   mem_address,
  output logic [DATA_WIDTH-1:0]   mem_write_data,
  output logic [DATA_WIDTH/8-1:0] mem_write_strb,
  input  logic [DATA_WIDTH-1:0]   mem_read_data,
  input  logic                    mem_response,
  output logic [2:0]              dbg_state
);

  bridge_state_e state;
  logic aw_held, w_held, pri_write;
  logic aw_hs, w_hs, ar_hs, aw_held_n, w_held_n;
  logic want_w, want_r, offer_now, offer_flip;
  logic wd_expired;

  assign aw_hs      = s_awvalid && s_awready;
  assign w_hs       = s_wvalid && s_wready;
  assign ar_hs      = s_arvalid && s_arready;
  assign aw_held_n  = aw_held | aw_hs;
  assign w_held_n   = w_held | w_hs;
  assign want_w     = s_awvalid | s_wvalid;
  assign want_r     = s_arvalid;
  assign offer_now  = offer_write(want_w, want_r, pri_write);
  assign offer_flip = offer_write(want_w, want_r, !pri_write);
  assign dbg_state  = state;

  // Protection bits and sub-word address bits have no meaning on the memory bus.
  logic unused_bits;
  assign unused_bits = ^{s_awprot, s_arprot, s_awaddr[1:0], s_araddr[1:0]};

`ifdef MEM_BRIDGE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wd_cnt;
  assign wd_expired = (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Watchdog: counts cycles spent waiting on the memory, restarts on every entry.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) wd_cnt <= '0;
    else if (state == ST_MEM_WR || state == ST_MEM_RD) wd_cnt <= wd_cnt + CNT_W'(1);
    else wd_cnt <= '0;
  end
`else
  // Without the watchdog the bridge waits on the memory indefinitely.
  assign wd_expired = 1'b0;
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

  // Bridge FSM: capture, arbitrate, drive the memory request, return B/R.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state          <= ST_IDLE;
      aw_held        <= 1'b0;
      w_held         <= 1'b0;
      pri_write      <= 1'b1;
      s_awready      <= 1'b0;
      s_wready       <= 1'b0;
      s_arready      <= 1'b0;
      s_bvalid       <= 1'b0;
      s_bresp        <= RESP_OKAY;
      s_rvalid       <= 1'b0;
      s_rdata        <= '0;
      s_rresp        <= RESP_OKAY;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_address    <= '0;
      mem_write_data <= '0;
      mem_write_strb <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (aw_hs) begin
            mem_address <= {s_awaddr[ADDR_WIDTH-1:2], 2'b00};
            aw_held     <= 1'b1;
          end
          if (w_hs) begin
            mem_write_data <= s_wdata;
            mem_write_strb <= s_wstrb;
            w_held         <= 1'b1;
          end
          if (aw_held_n && w_held_n) begin
            state     <= ST_MEM_WR;
            mem_write <= 1'b1;
            s_awready <= 1'b0;
            s_wready  <= 1'b0;
            s_arready <= 1'b0;
          end else if (aw_held_n || w_held_n) begin
            // Half a write is captured: finish it before any read is offered.
            s_awready <= !aw_held_n;
            s_wready  <= !w_held_n;
            s_arready <= 1'b0;
          end else if (ar_hs) begin
            mem_address <= {s_araddr[ADDR_WIDTH-1:2], 2'b00};
            state       <= ST_MEM_RD;
            mem_read    <= 1'b1;
            s_awready   <= 1'b0;
            s_wready    <= 1'b0;
            s_arready   <= 1'b0;
          end else begin
            s_awready <= offer_now;
            s_wready  <= offer_now;
            s_arready <= !offer_now;
          end
        end
        ST_MEM_WR: begin
          if (mem_response || wd_expired) begin
            mem_write <= 1'b0;
            s_bvalid  <= 1'b1;
            s_bresp   <= mem_response ? RESP_OKAY : RESP_SLVERR;
            state     <= ST_B_RESP;
          end
        end
        ST_MEM_RD: begin
          if (mem_response || wd_expired) begin
            mem_read <= 1'b0;
            s_rvalid <= 1'b1;
            s_rdata  <= mem_response ? mem_read_data : '0;
            s_rresp  <= mem_response ? RESP_OKAY : RESP_SLVERR;
            state    <= ST_R_RESP;
          end
        end
        ST_B_RESP: begin
          if (s_bready) begin
            s_bvalid  <= 1'b0;
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            pri_write <= !pri_write;
            s_awready <= offer_flip;
            s_wready  <= offer_flip;
            s_arready <= !offer_flip;
            state     <= ST_IDLE;
          end
        end
        ST_R_RESP: begin
          if (s_rready) begin
            s_rvalid  <= 1'b0;
            pri_write <= !pri_write;
            s_awready <= offer_flip;
            s_wready  <= offer_flip;
            s_arready <= !offer_flip;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_mem_bridge.sv
// Directed testbench for axil_mem_bridge: write/read paths, AW/W ordering,
// read gating, backpressure, round-robin arbitration, async reset and the
// optional memory watchdog (MEM_BRIDGE_TIMEOUT_EN, TIMEOUT_CYCLES=8).
module tb_axil_mem_bridge;

  logic        clk, rstn;
  logic        s_awvalid, s_awready, s_wvalid, s_wready;
  logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
  logic [2:0]  s_awprot, s_arprot;
  logic [3:0]  s_wstrb;
  logic        s_bvalid, s_bready, s_arvalid, s_arready, s_rvalid, s_rready;
  logic [1:0]  s_bresp, s_rresp;
  logic        mem_read, mem_write, mem_response;
  logic [31:0] mem_address, mem_write_data, mem_read_data;
  logic [3:0]  mem_write_strb;
  logic [2:0]  dbg_state;

  int checks = 0;
  int failures = 0;
  bit both_hi = 0;
  logic [0:0] exp_q[$];

  axil_mem_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rstn(rstn),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awprot(s_awprot),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arprot(s_arprot),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_write_strb(mem_write_strb),
    .mem_read_data(mem_read_data), .mem_response(mem_response), .dbg_state(dbg_state)
  );

  // Clock and global time limit
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "time limit");
  end

  // Mutual exclusion monitor on the memory request lines
  always @(negedge clk) if (mem_read && mem_write) both_hi = 1'b1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive whichever of AW/W is valid until each has handshaken.
  task automatic drive_aw_w(output bit done);
    bit aw_done, w_done;
    aw_done = !s_awvalid;
    w_done  = !s_wvalid;
    done    = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bit aw_f, w_f;
      aw_f = s_awvalid && s_awready;
      w_f  = s_wvalid && s_wready;
      tick();
      if (aw_f) begin s_awvalid = 1'b0; aw_done = 1'b1; end
      if (w_f)  begin s_wvalid = 1'b0;  w_done = 1'b1;  end
      if (aw_done && w_done) begin done = 1'b1; break; end
    end
  endtask

  task automatic drive_ar(output bit done);
    done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bit f;
      f = s_arvalid && s_arready;
      tick();
      if (f) begin s_arvalid = 1'b0; done = 1'b1; break; end
    end
  endtask

  initial begin
    bit done, flag_a, flag_b;
    int cnt, resp_iter, bv_iter, grants;
    logic prev_mw, prev_mr;

    rstn = 1'b0; s_awvalid = 0; s_wvalid = 0; s_arvalid = 0; s_bready = 0; s_rready = 0;
    s_awaddr = 0; s_wdata = 0; s_wstrb = 0; s_araddr = 0; s_awprot = 0; s_arprot = 0;
    mem_response = 0; mem_read_data = 0;
    tick(); tick();

    // Reset state
    check_eq("rst_awready", s_awready, 0);
    check_eq("rst_wready", s_wready, 0);
    check_eq("rst_arready", s_arready, 0);
    check_eq("rst_bvalid", s_bvalid, 0);
    check_eq("rst_rvalid", s_rvalid, 0);
    check_eq("rst_mem_rw", {mem_read, mem_write}, 0);
    check_eq("rst_state", dbg_state, 0);
    rstn = 1'b1;

    // 1: AW+W together, response in the third mem_write cycle
    s_awaddr = 32'h100; s_wdata = 32'hCAFEBABE; s_wstrb = 4'hF;
    s_awvalid = 1; s_wvalid = 1;
    drive_aw_w(done);
    check_eq("t1_hs", done, 1);
    check_eq("t1_mem_write", mem_write, 1);
    check_eq("t1_mem_read", mem_read, 0);
    check_eq("t1_addr", mem_address, 32'h100);
    check_eq("t1_wdata", mem_write_data, 32'hCAFEBABE);
    check_eq("t1_wstrb", mem_write_strb, 4'hF);
    cnt = 0; resp_iter = -1; bv_iter = -1;
    for (int i = 0; i < 20; i++) begin
      if (s_bvalid) begin bv_iter = i; break; end
      if (mem_write) cnt++;
      mem_response = (cnt == 3) && mem_write;
      if (mem_response) resp_iter = i;
      tick();
      mem_response = 0;
    end
    check_eq("t1_mw_cycles", cnt, 3);
    check_eq("t1_bvalid_lat", bv_iter - resp_iter, 1);
    check_eq("t1_bresp", s_bresp, 2'b00);
    check_eq("t1_mw_drop", mem_write, 0);
    tick();
    check_eq("t1_bvalid_hold", s_bvalid, 1);
    s_bready = 1; tick(); s_bready = 0;
    check_eq("t1_bvalid_clr", s_bvalid, 0);
    check_eq("t1_idle", dbg_state, 0);

    // 2: W first, AW three cycles later; read must be held off meanwhile
    s_wdata = 32'h55AA55AA; s_wstrb = 4'h3; s_wvalid = 1;
    drive_aw_w(done);
    check_eq("t2_w_hs", done, 1);
    check_eq("t2_wready_drop", s_wready, 0);
    s_araddr = 32'h204; s_arvalid = 1;
    flag_a = 0; flag_b = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      flag_a |= s_arready;
      flag_b |= mem_write;
    end
    check_eq("t2_arready_gated", flag_a, 0);
    check_eq("t2_no_early_write", flag_b, 0);
    s_awaddr = 32'h1A6; s_awvalid = 1;
    drive_aw_w(done);
    check_eq("t2_aw_hs", done, 1);
    check_eq("t2_mem_write", mem_write, 1);
    check_eq("t2_addr", mem_address, 32'h1A4);
    check_eq("t2_wdata", mem_write_data, 32'h55AA55AA);
    check_eq("t2_wstrb", mem_write_strb, 4'h3);
    mem_response = 1; tick(); mem_response = 0;
    check_eq("t2_bvalid", s_bvalid, 1);
    s_bready = 1; tick(); s_bready = 0;

    // 3: pending read of 0x204 with R backpressure
    drive_ar(done);
    check_eq("t3_ar_hs", done, 1);
    check_eq("t3_mem_read", mem_read, 1);
    check_eq("t3_addr", mem_address, 32'h204);
    check_eq("t3_no_write", mem_write, 0);
    tick();
    mem_read_data = 32'h12345678; mem_response = 1;
    tick();
    mem_response = 0; mem_read_data = 32'hDEADBEEF;
    check_eq("t3_rvalid", s_rvalid, 1);
    check_eq("t3_rdata", s_rdata, 32'h12345678);
    check_eq("t3_rresp", s_rresp, 2'b00);
    check_eq("t3_mr_drop", mem_read, 0);
    flag_a = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      flag_a &= s_rvalid && (s_rdata == 32'h12345678);
    end
    check_eq("t3_r_stable", flag_a, 1);
    s_rready = 1; tick(); s_rready = 0;
    check_eq("t3_rvalid_clr", s_rvalid, 0);
    check_eq("t3_idle", dbg_state, 0);

    // 5: reset asserted while a write is on the memory bus
    s_awaddr = 32'h40; s_wdata = 32'h11112222; s_wstrb = 4'hF;
    s_awvalid = 1; s_wvalid = 1;
    drive_aw_w(done);
    check_eq("t5_mem_write", mem_write, 1);
    #3 rstn = 1'b0;
    #1;
    check_eq("t5_async_mw", mem_write, 0);
    check_eq("t5_async_addr", mem_address, 0);
    check_eq("t5_async_rdata", s_rdata, 0);
    check_eq("t5_async_state", dbg_state, 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    tick();
    check_eq("t5_awready", s_awready, 1);
    check_eq("t5_wready", s_wready, 1);
    check_eq("t5_arready", s_arready, 0);

    // 4: simultaneous read and write requests, back to back
    exp_q.push_back(1'b1); exp_q.push_back(1'b0); exp_q.push_back(1'b1); exp_q.push_back(1'b0);
    s_awaddr = 32'h500; s_wdata = 32'hA5A5A5A5; s_araddr = 32'h600;
    s_awvalid = 1; s_wvalid = 1; s_arvalid = 1; s_bready = 1; s_rready = 1;
    grants = 0; prev_mw = 0; prev_mr = 0;
    for (int i = 0; i < 200; i++) begin
      bit aw_f, w_f, ar_f;
      if ((mem_write && !prev_mw) || (mem_read && !prev_mr)) begin
        check_eq("t4_grant_order", mem_write, (exp_q.size() != 0) ? exp_q.pop_front() : 1'bx);
        grants++;
      end
      prev_mw = mem_write; prev_mr = mem_read;
      if (grants >= 4) begin s_awvalid = 0; s_wvalid = 0; s_arvalid = 0; end
      if (grants >= 4 && dbg_state == 0 && !s_bvalid && !s_rvalid) break;
      mem_response = (mem_read || mem_write) && !mem_response;
      mem_read_data = 32'hA0000000 + i;
      aw_f = s_awvalid && s_awready;
      w_f = s_wvalid && s_wready;
      ar_f = s_arvalid && s_arready;
      tick();
      if (aw_f) s_awaddr = s_awaddr + 4;
      if (w_f) s_wdata = s_wdata + 1;
      if (ar_f) s_araddr = s_araddr + 4;
    end
    mem_response = 0; s_bready = 0; s_rready = 0;
    check_eq("t4_grants", grants, 4);
    check_eq("t4_queue_empty", exp_q.size(), 0);
    check_eq("t4_idle", dbg_state, 0);

    // 6: memory never answers a read
    s_araddr = 32'h80; s_arvalid = 1;
    drive_ar(done);
    check_eq("t6_ar_hs", done, 1);
`ifdef MEM_BRIDGE_TIMEOUT_EN
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      if (s_rvalid) break;
      if (mem_read) cnt++;
      tick();
    end
    check_eq("t6_mr_cycles", cnt, 8);
    check_eq("t6_rvalid", s_rvalid, 1);
    check_eq("t6_rresp", s_rresp, 2'b10);
    check_eq("t6_rdata", s_rdata, 0);
    check_eq("t6_mr_drop", mem_read, 0);
`else
    flag_a = 1; flag_b = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      flag_a &= mem_read;
      flag_b |= s_rvalid;
    end
    check_eq("t6_still_waiting", flag_a, 1);
    check_eq("t6_no_rvalid", flag_b, 0);
    mem_read_data = 32'hFEEDF00D; mem_response = 1;
    tick();
    mem_response = 0;
    check_eq("t6_rdata", s_rdata, 32'hFEEDF00D);
    check_eq("t6_rresp", s_rresp, 2'b00);
`endif
    s_rready = 1; tick(); s_rready = 0;
    check_eq("t6_idle", dbg_state, 0);

    check_eq("never_both_rw", both_hi, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
